// File: rtl/full_adder_1bit_core.sv
// Single-bit full adder leaf cell.
// Provides a zero-latency combinational sum/carry path and a registered copy.
// The registered copy has an optional carry-feedback mode for LSB-first bit-serial addition.
module full_adder_1bit_core (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout,
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic serial,
   input  logic clr,
   output logic sum_q,
   output logic cout_q,
   output logic valid_q
);

   logic w_en;
   logic w_serial;
   logic w_clr;
   logic w_cin_eff;
   logic w_sum;
   logic w_cout;

   logic r_carry;
   logic r_sum;
   logic r_valid;

   // Control inputs left open or unknown resolve to 0, like a pull-down; in hardware these are
   // plain wires.
   always_comb begin
      w_en     = (en === 1'b1);
      w_serial = (serial === 1'b1);
      w_clr    = (clr === 1'b1);
   end

   // Adder core, shared by the combinational outputs and the register stage.
   always_comb begin
      w_cin_eff = w_serial ? r_carry : cin;
      w_sum     = a ^ b ^ w_cin_eff;
      w_cout    = (a & b) | (a & w_cin_eff) | (b & w_cin_eff);
   end

   // Registered copy: clear has priority over capture, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry <= 1'b0;
         r_sum   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_clr) begin
         r_carry <= 1'b0;
         r_sum   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_en) begin
         r_carry <= w_cout;
         r_sum   <= w_sum;
         r_valid <= 1'b1;
      end
   end

   assign sum     = w_sum;
   assign cout    = w_cout;
   assign sum_q   = r_sum;
   assign cout_q  = r_carry;
   assign valid_q = r_valid;

endmodule

// File: tb/tb_full_adder_1bit_core.sv
// Self-checking bench for full_adder_1bit_core.
// An arithmetic reference model is compared against the DUT every cycle, with directed literal checks.
module tb_full_adder_1bit_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a = 1'b0, b = 1'b0, cin = 1'b0;
   logic en = 1'b0, serial = 1'b0, clr = 1'b0;
   logic sum, cout, sum_q, cout_q, valid_q;

   int total = 0;
   int bad = 0;

   // Reference model state.
   logic m_carry = 1'b0;
   logic m_sum = 1'b0;
   logic m_valid = 1'b0;

   full_adder_1bit_core dut (
      .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .clk(clk), .rst_n(rst_n), .en(en), .serial(serial), .clr(clr),
      .sum_q(sum_q), .cout_q(cout_q), .valid_q(valid_q)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_total();
      int eff;
      eff = serial ? int'(m_carry) : int'(cin);
      return int'(a) + int'(b) + eff;
   endfunction

   // Model of the register stage, written as arithmetic on the bit total.
   always @(posedge clk or negedge rst_n) begin
      int t;
      if (!rst_n) begin
         m_carry = 1'b0; m_sum = 1'b0; m_valid = 1'b0;
      end else if (clr) begin
         m_carry = 1'b0; m_sum = 1'b0; m_valid = 1'b0;
      end else if (en) begin
         t = model_total();
         m_sum = logic'(t % 2);
         m_carry = logic'(t / 2);
         m_valid = 1'b1;
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      int t;
      t = model_total();
      chk("m_sum", sum, logic'(t % 2));
      chk("m_cout", cout, logic'(t / 2));
      chk("m_sum_q", sum_q, m_sum);
      chk("m_cout_q", cout_q, m_carry);
      chk("m_valid_q", valid_q, m_valid);
   end

   task automatic drive(input logic ia, ib, ic, ien, iser, iclr);
      a = ia; b = ib; cin = ic; en = ien; serial = iser; clr = iclr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] tt_sum;
      logic [7:0] tt_cout;
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] exp_seq;
      tt_sum  = 8'b1001_0110;
      tt_cout = 8'b1110_1000;

      // Reset state.
      tick(); tick();
      chk("rst_sum_q", sum_q, 1'b0);
      chk("rst_cout_q", cout_q, 1'b0);
      chk("rst_valid_q", valid_q, 1'b0);
      rst_n = 1'b1;
      tick();

      // Exhaustive truth table, serial=0, en=0.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         drive(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0);
         #1;
         chk("tt_sum", sum, tt_sum[i]);
         chk("tt_cout", cout, tt_cout[i]);
         tick();
      end
      chk("tt_no_capture", valid_q, 1'b0);

      // Subtract usage: b pre-inverted, cin=1.
      drive(1'b1, ~1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("sub10_sum", sum, 1'b1); chk("sub10_cout", cout, 1'b1);
      drive(1'b0, ~1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("sub01_sum", sum, 1'b1); chk("sub01_cout", cout, 1'b0);
      drive(1'b1, ~1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("sub11_sum", sum, 1'b0); chk("sub11_cout", cout, 1'b1);
      tick();

      // Registered capture then hold.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cap_sum_q", sum_q, 1'b1);
      chk("cap_cout_q", cout_q, 1'b1);
      chk("cap_valid_q", valid_q, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk("hold_sum_q", sum_q, 1'b1);
      chk("hold_cout_q", cout_q, 1'b1);
      chk("hold_valid_q", valid_q, 1'b1);

      // Clear with en=1 in the same cycle: clear wins.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("clr_en_sum_q", sum_q, 1'b0);
      chk("clr_en_cout_q", cout_q, 1'b0);
      chk("clr_en_valid_q", valid_q, 1'b0);

      // Serial 0111 + 0011 = 1010, LSB first.
      x = 4'b0111; y = 4'b0011; exp_seq = 4'b1010;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(x[i], y[i], 1'b0, 1'b1, 1'b1, 1'b0);
         tick();
         chk("ser_sum_q", sum_q, exp_seq[i]);
      end
      chk("ser_final_cout_q", cout_q, 1'b0);

      // Asynchronous reset in the middle of a serial add.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("mid_carry_set", cout_q, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_sum_q", sum_q, 1'b0);
      chk("arst_cout_q", cout_q, 1'b0);
      chk("arst_valid_q", valid_q, 1'b0);
      chk("arst_comb_sum", sum, 1'b1);
      chk("arst_comb_cout", cout, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("post_rst_sum_q", sum_q, 1'b0);
      chk("post_rst_cout_q", cout_q, 1'b1);

      // Random stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 39) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         tick();
      end

      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
